// File: rtl/retire_pair_aligner.sv
// rtl/retire_pair_aligner.sv - pairs retirement records from two CPU copies in strict per-copy FIFO order
module retire_pair_aligner #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            retire_1_i,
  input  logic [XLEN-1:0] instr_1_i,
  input  logic [XLEN-1:0] reg_rs1_1_i,
  input  logic [XLEN-1:0] reg_rs2_1_i,
  input  logic [XLEN-1:0] reg_rd_1_i,
  input  logic [XLEN-1:0] mem_addr_1_i,
  input  logic [XLEN-1:0] mem_r_data_1_i,
  input  logic [XLEN-1:0] mem_w_data_1_i,
  input  logic            retire_2_i,
  input  logic [XLEN-1:0] instr_2_i,
  input  logic [XLEN-1:0] reg_rs1_2_i,
  input  logic [XLEN-1:0] reg_rs2_2_i,
  input  logic [XLEN-1:0] reg_rd_2_i,
  input  logic [XLEN-1:0] mem_addr_2_i,
  input  logic [XLEN-1:0] mem_r_data_2_i,
  input  logic [XLEN-1:0] mem_w_data_2_i,
  output logic            stall_1_o,
  output logic            stall_2_o,
  output logic            retire_o,
  output logic [XLEN-1:0] instr_1_o,
  output logic [XLEN-1:0] reg_rs1_1_o,
  output logic [XLEN-1:0] reg_rs2_1_o,
  output logic [XLEN-1:0] reg_rd_1_o,
  output logic [XLEN-1:0] mem_addr_1_o,
  output logic [XLEN-1:0] mem_r_data_1_o,
  output logic [XLEN-1:0] mem_w_data_1_o,
  output logic [XLEN-1:0] instr_2_o,
  output logic [XLEN-1:0] reg_rs1_2_o,
  output logic [XLEN-1:0] reg_rs2_2_o,
  output logic [XLEN-1:0] reg_rd_2_o,
  output logic [XLEN-1:0] mem_addr_2_o,
  output logic [XLEN-1:0] mem_r_data_2_o,
  output logic [XLEN-1:0] mem_w_data_2_o,
  output logic            overflow_o,
  output logic [31:0]     pairs_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = 7 * XLEN;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [RW-1:0] mem_1 [DEPTH];
  logic [RW-1:0] mem_2 [DEPTH];
  logic [AW-1:0] wr_1, rd_1, wr_2, rd_2;
  logic [AW:0]   cnt_1, cnt_2;
  logic [RW-1:0] rec_1, rec_2, out_1, out_2;
  logic          pop, push_1, push_2, drop_1, drop_2;

  assign rec_1 = {instr_1_i, reg_rs1_1_i, reg_rs2_1_i, reg_rd_1_i,
                  mem_addr_1_i, mem_r_data_1_i, mem_w_data_1_i};
  assign rec_2 = {instr_2_i, reg_rs1_2_i, reg_rs2_2_i, reg_rd_2_i,
                  mem_addr_2_i, mem_r_data_2_i, mem_w_data_2_i};

  // A full FIFO may still accept a record on an edge that pops its head,
  // since the head slot is read out on that same edge.
  assign pop    = (cnt_1 != '0) && (cnt_2 != '0);
  assign push_1 = retire_1_i && ((cnt_1 < FULL) || pop);
  assign push_2 = retire_2_i && ((cnt_2 < FULL) || pop);
  assign drop_1 = retire_1_i && !push_1;
  assign drop_2 = retire_2_i && !push_2;

  assign stall_1_o = (cnt_1 == FULL);
  assign stall_2_o = (cnt_2 == FULL);

  assign {instr_1_o, reg_rs1_1_o, reg_rs2_1_o, reg_rd_1_o,
          mem_addr_1_o, mem_r_data_1_o, mem_w_data_1_o} = out_1;
  assign {instr_2_o, reg_rs1_2_o, reg_rs2_2_o, reg_rd_2_o,
          mem_addr_2_o, mem_r_data_2_o, mem_w_data_2_o} = out_2;

  always_ff @(posedge clk_i) begin
    if (!rst_i && push_1) mem_1[wr_1] <= rec_1;
    if (!rst_i && push_2) mem_2[wr_2] <= rec_2;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_1       <= '0;
      rd_1       <= '0;
      cnt_1      <= '0;
      wr_2       <= '0;
      rd_2       <= '0;
      cnt_2      <= '0;
      retire_o   <= 1'b0;
      out_1      <= '0;
      out_2      <= '0;
      overflow_o <= 1'b0;
      pairs_o    <= '0;
    end else begin
      if (push_1) wr_1 <= wr_1 + 1'b1;
      if (push_2) wr_2 <= wr_2 + 1'b1;
      if (pop) begin
        rd_1 <= rd_1 + 1'b1;
        rd_2 <= rd_2 + 1'b1;
      end
      if (push_1 && !pop)      cnt_1 <= cnt_1 + 1'b1;
      else if (!push_1 && pop) cnt_1 <= cnt_1 - 1'b1;
      if (push_2 && !pop)      cnt_2 <= cnt_2 + 1'b1;
      else if (!push_2 && pop) cnt_2 <= cnt_2 - 1'b1;
      retire_o <= pop;
      if (pop) begin
        out_1   <= mem_1[rd_1];
        out_2   <= mem_2[rd_2];
        pairs_o <= pairs_o + 32'd1;
      end
      if (drop_1 || drop_2) overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_retire_pair_aligner.sv
// tb/tb_retire_pair_aligner.sv - directed self-checking bench for retire_pair_aligner
module tb_retire_pair_aligner;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        retire_1_i, retire_2_i;
  logic [31:0] instr_1_i, reg_rs1_1_i, reg_rs2_1_i, reg_rd_1_i, mem_addr_1_i, mem_r_data_1_i, mem_w_data_1_i;
  logic [31:0] instr_2_i, reg_rs1_2_i, reg_rs2_2_i, reg_rd_2_i, mem_addr_2_i, mem_r_data_2_i, mem_w_data_2_i;
  logic        stall_1_o, stall_2_o, retire_o, overflow_o;
  logic [31:0] instr_1_o, reg_rs1_1_o, reg_rs2_1_o, reg_rd_1_o, mem_addr_1_o, mem_r_data_1_o, mem_w_data_1_o;
  logic [31:0] instr_2_o, reg_rs1_2_o, reg_rs2_2_o, reg_rd_2_o, mem_addr_2_o, mem_r_data_2_o, mem_w_data_2_o;
  logic [31:0] pairs_o;
  logic [447:0] all_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign all_data = {instr_1_o, reg_rs1_1_o, reg_rs2_1_o, reg_rd_1_o, mem_addr_1_o, mem_r_data_1_o, mem_w_data_1_o,
                     instr_2_o, reg_rs1_2_o, reg_rs2_2_o, reg_rd_2_o, mem_addr_2_o, mem_r_data_2_o, mem_w_data_2_o};

  retire_pair_aligner #(.DEPTH(4), .XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .retire_1_i(retire_1_i), .instr_1_i(instr_1_i), .reg_rs1_1_i(reg_rs1_1_i), .reg_rs2_1_i(reg_rs2_1_i),
    .reg_rd_1_i(reg_rd_1_i), .mem_addr_1_i(mem_addr_1_i), .mem_r_data_1_i(mem_r_data_1_i), .mem_w_data_1_i(mem_w_data_1_i),
    .retire_2_i(retire_2_i), .instr_2_i(instr_2_i), .reg_rs1_2_i(reg_rs1_2_i), .reg_rs2_2_i(reg_rs2_2_i),
    .reg_rd_2_i(reg_rd_2_i), .mem_addr_2_i(mem_addr_2_i), .mem_r_data_2_i(mem_r_data_2_i), .mem_w_data_2_i(mem_w_data_2_i),
    .stall_1_o(stall_1_o), .stall_2_o(stall_2_o), .retire_o(retire_o),
    .instr_1_o(instr_1_o), .reg_rs1_1_o(reg_rs1_1_o), .reg_rs2_1_o(reg_rs2_1_o), .reg_rd_1_o(reg_rd_1_o),
    .mem_addr_1_o(mem_addr_1_o), .mem_r_data_1_o(mem_r_data_1_o), .mem_w_data_1_o(mem_w_data_1_o),
    .instr_2_o(instr_2_o), .reg_rs1_2_o(reg_rs1_2_o), .reg_rs2_2_o(reg_rs2_2_o), .reg_rd_2_o(reg_rd_2_o),
    .mem_addr_2_o(mem_addr_2_o), .mem_r_data_2_o(mem_r_data_2_o), .mem_w_data_2_o(mem_w_data_2_o),
    .overflow_o(overflow_o), .pairs_o(pairs_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_1(input logic en, input logic [31:0] v);
    retire_1_i = en; instr_1_i = v; reg_rs1_1_i = v + 1; reg_rs2_1_i = v + 2; reg_rd_1_i = v + 3;
    mem_addr_1_i = v + 4; mem_r_data_1_i = v + 5; mem_w_data_1_i = v + 6;
  endtask

  task automatic drive_2(input logic en, input logic [31:0] v);
    retire_2_i = en; instr_2_i = v; reg_rs1_2_i = v + 1; reg_rs2_2_i = v + 2; reg_rd_2_i = v + 3;
    mem_addr_2_i = v + 4; mem_r_data_2_i = v + 5; mem_w_data_2_i = v + 6;
  endtask

  task automatic do_reset;
    rst_i = 1'b1;
    drive_1(1'b0, 32'h0);
    drive_2(1'b0, 32'h0);
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({retire_o, overflow_o, stall_1_o, stall_2_o} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {retire_o, overflow_o, stall_1_o, stall_2_o});
    end
    checks++;
    if (pairs_o !== 32'd0) begin errors++; $display("FAIL reset_pairs got %0d want 0", pairs_o); end
    checks++;
    if (all_data !== '0) begin errors++; $display("FAIL reset_data got nonzero want 0"); end
  endtask

  task automatic test_lockstep_single;
    drive_1(1'b1, 32'h00500093); reg_rd_1_i = 32'd5;
    drive_2(1'b1, 32'h00500093); reg_rd_2_i = 32'd5;
    tick();
    checks++;
    if (retire_o !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", retire_o); end
    drive_1(1'b0, 32'h0); drive_2(1'b0, 32'h0);
    tick();
    checks++;
    if (retire_o !== 1'b1) begin errors++; $display("FAIL single_retire got %b want 1", retire_o); end
    checks++;
    if (instr_1_o !== 32'h00500093 || instr_2_o !== 32'h00500093) begin
      errors++; $display("FAIL single_instr got %h/%h want 00500093", instr_1_o, instr_2_o);
    end
    checks++;
    if (reg_rd_1_o !== 32'd5 || reg_rd_2_o !== 32'd5 || mem_w_data_1_o !== 32'h00500099) begin
      errors++; $display("FAIL single_fields got rd %0d/%0d wdata %h want 5/5 00500099", reg_rd_1_o, reg_rd_2_o, mem_w_data_1_o);
    end
    checks++;
    if (pairs_o !== 32'd1) begin errors++; $display("FAIL single_pairs got %0d want 1", pairs_o); end
    tick();
    checks++;
    if (retire_o !== 1'b0 || instr_1_o !== 32'h00500093 || pairs_o !== 32'd1) begin
      errors++; $display("FAIL single_hold got retire %b instr %h pairs %0d want 0 00500093 1", retire_o, instr_1_o, pairs_o);
    end
  endtask

  task automatic test_skew;
    logic [31:0] exp_v;
    for (int i = 0; i < 10; i++) begin
      drive_1(i < 3, 32'h100 * (i + 1));
      drive_2(i >= 5 && i < 8, 32'h100 * (i - 4));
      tick();
      checks++;
      if (retire_o !== (i >= 6 && i <= 8)) begin
        errors++; $display("FAIL skew_retire edge %0d got %b want %b", i, retire_o, (i >= 6 && i <= 8));
      end
      if (i >= 6 && i <= 8) begin
        exp_v = 32'h100 * (i - 5);
        checks++;
        if (instr_1_o !== exp_v || instr_2_o !== exp_v) begin
          errors++; $display("FAIL skew_pair edge %0d got %h/%h want %h", i, instr_1_o, instr_2_o, exp_v);
        end
      end
    end
    checks++;
    if (overflow_o !== 1'b0 || pairs_o !== 32'd4) begin
      errors++; $display("FAIL skew_end got ovf %b pairs %0d want 0 4", overflow_o, pairs_o);
    end
  endtask

  task automatic test_full_drop;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_1(1'b1, 32'h1000 + i);
      tick();
      checks++;
      if (stall_1_o !== (i >= 3)) begin errors++; $display("FAIL full_stall push %0d got %b want %b", i, stall_1_o, (i >= 3)); end
      checks++;
      if (overflow_o !== (i == 4)) begin errors++; $display("FAIL full_ovf push %0d got %b want %b", i, overflow_o, (i == 4)); end
    end
    drive_1(1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      drive_2(i < 4, 32'h2000 + i);
      tick();
      checks++;
      if (retire_o !== (i >= 1)) begin errors++; $display("FAIL full_retire step %0d got %b want %b", i, retire_o, (i >= 1)); end
      if (i >= 1) begin
        checks++;
        if (instr_1_o !== 32'h1000 + i - 1 || instr_2_o !== 32'h2000 + i - 1) begin
          errors++; $display("FAIL full_pair step %0d got %h/%h want %h/%h", i, instr_1_o, instr_2_o, 32'h1000 + i - 1, 32'h2000 + i - 1);
        end
      end
      if (i < 2) begin
        checks++;
        if (stall_1_o !== (i == 0)) begin errors++; $display("FAIL full_unstall step %0d got %b want %b", i, stall_1_o, (i == 0)); end
      end
    end
    drive_2(1'b0, 32'h0);
    tick();
    checks++;
    if (retire_o !== 1'b0 || overflow_o !== 1'b1 || pairs_o !== 32'd4) begin
      errors++; $display("FAIL full_end got retire %b ovf %b pairs %0d want 0 1 4", retire_o, overflow_o, pairs_o);
    end
  endtask

  task automatic test_push_full_pop;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_1(1'b1, 32'h3000 + i);
      tick();
    end
    drive_1(1'b0, 32'h0);
    drive_2(1'b1, 32'h4000);
    tick();
    checks++;
    if (retire_o !== 1'b0 || stall_1_o !== 1'b1) begin
      errors++; $display("FAIL pf_pre got retire %b stall %b want 0 1", retire_o, stall_1_o);
    end
    drive_1(1'b1, 32'h3004);
    drive_2(1'b1, 32'h4001);
    tick();
    checks++;
    if (retire_o !== 1'b1 || instr_1_o !== 32'h3000 || instr_2_o !== 32'h4000) begin
      errors++; $display("FAIL pf_first got %b %h/%h want 1 3000/4000", retire_o, instr_1_o, instr_2_o);
    end
    checks++;
    if (overflow_o !== 1'b0 || stall_1_o !== 1'b1) begin
      errors++; $display("FAIL pf_accept got ovf %b stall %b want 0 1", overflow_o, stall_1_o);
    end
    drive_1(1'b0, 32'h0);
    for (int j = 0; j < 4; j++) begin
      drive_2(j < 3, 32'h4002 + j);
      tick();
      checks++;
      if (retire_o !== 1'b1 || instr_1_o !== 32'h3001 + j || instr_2_o !== 32'h4001 + j) begin
        errors++; $display("FAIL pf_pair %0d got %b %h/%h want 1 %h/%h", j, retire_o, instr_1_o, instr_2_o, 32'h3001 + j, 32'h4001 + j);
      end
    end
    drive_2(1'b0, 32'h0);
    checks++;
    if (pairs_o !== 32'd5 || overflow_o !== 1'b0 || stall_1_o !== 1'b0) begin
      errors++; $display("FAIL pf_end got pairs %0d ovf %b stall %b want 5 0 0", pairs_o, overflow_o, stall_1_o);
    end
  endtask

  task automatic test_wrap;
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      drive_1(i < 10, i);
      drive_2(i < 10, i);
      tick();
      if (i >= 1) begin
        checks++;
        if (retire_o !== 1'b1 || instr_1_o !== 32'(i - 1) || instr_2_o !== 32'(i - 1)) begin
          errors++; $display("FAIL wrap_pair %0d got %b %h/%h want 1 %h", i, retire_o, instr_1_o, instr_2_o, i - 1);
        end
      end
    end
    tick();
    checks++;
    if (retire_o !== 1'b0 || pairs_o !== 32'd10) begin
      errors++; $display("FAIL wrap_end got retire %b pairs %0d want 0 10", retire_o, pairs_o);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_1(1'b1, 32'h5000 + i);
      drive_2(1'b1, 32'h5000 + i);
      tick();
    end
    drive_2(1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      drive_1(1'b1, 32'h6000 + i);
      tick();
    end
    drive_1(1'b0, 32'h0);
    drive_2(1'b1, 32'h7000);
    tick();
    drive_2(1'b0, 32'h0);
    tick();
    checks++;
    if (pairs_o !== 32'd7 || overflow_o !== 1'b1 || stall_1_o !== 1'b0 || instr_1_o !== 32'h6000) begin
      errors++; $display("FAIL mid_pre got pairs %0d ovf %b stall %b instr %h want 7 1 0 6000", pairs_o, overflow_o, stall_1_o, instr_1_o);
    end
    rst_i = 1'b1;
    drive_1(1'b1, 32'h9000);
    drive_2(1'b1, 32'h9000);
    tick();
    rst_i = 1'b0;
    drive_1(1'b0, 32'h0);
    drive_2(1'b0, 32'h0);
    checks++;
    if ({retire_o, overflow_o, stall_1_o, stall_2_o} !== 4'b0 || pairs_o !== 32'd0 || all_data !== '0) begin
      errors++; $display("FAIL mid_reset got flags %b pairs %0d want 0000 0", {retire_o, overflow_o, stall_1_o, stall_2_o}, pairs_o);
    end
    tick();
    checks++;
    if (retire_o !== 1'b0 || pairs_o !== 32'd0) begin
      errors++; $display("FAIL mid_ignored got retire %b pairs %0d want 0 0", retire_o, pairs_o);
    end
    drive_1(1'b1, 32'h8000);
    drive_2(1'b1, 32'h8000);
    tick();
    drive_1(1'b0, 32'h0);
    drive_2(1'b0, 32'h0);
    tick();
    checks++;
    if (retire_o !== 1'b1 || pairs_o !== 32'd1 || instr_1_o !== 32'h8000 || instr_2_o !== 32'h8000) begin
      errors++; $display("FAIL mid_after got %b pairs %0d %h/%h want 1 1 8000/8000", retire_o, pairs_o, instr_1_o, instr_2_o);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    drive_1(1'b0, 32'h0);
    drive_2(1'b0, 32'h0);
    test_reset();
    test_lockstep_single();
    test_skew();
    test_full_drop();
    test_push_full_pop();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/retire_pair_aligner.md
# retire_pair_aligner

Upstream companion of the contract checker in the two-copy (product) verification harness. Two CVA6 instances retire instructions at independent times. This block buffers each copy's retirement records in a per-copy FIFO and releases them strictly in order, one record from each copy at a time. It drives a single `retire_o` pulse together with both records, which the checker then compares field-by-field. It also raises backpressure to a copy that runs too far ahead, flags dropped records, and counts emitted pairs.

## Interface
- `DEPTH`, 4: records per copy FIFO; power of two, ≥2.
- `XLEN`, 32: width of every data field.
- `clk_i` in 1: clock; all state updates on posedge.
- `rst_i` in 1: reset; synchronous, active-high.
- `retire_k_i` in 1 (k=1,2): copy k retires one instruction this cycle.
- `instr_k_i`, `reg_rs1_k_i`, `reg_rs2_k_i`, `reg_rd_k_i`, `mem_addr_k_i`, `mem_r_data_k_i`, `mem_w_data_k_i` in XLEN each: copy k retirement record, valid when `retire_k_i`=1.
- `stall_k_o` out 1: FIFO k is full (count_k == DEPTH); the harness freezes copy k.
- `retire_o` out 1: one-cycle pulse; a pair is presented on the outputs.
- `instr_k_o`, `reg_rs1_k_o`, `reg_rs2_k_o`, `reg_rd_k_o`, `mem_addr_k_o`, `mem_r_data_k_o`, `mem_w_data_k_o` out XLEN each: paired record for copy k.
- `overflow_o` out 1: sticky; a record was dropped.
- `pairs_o` out 32: number of pairs emitted since reset; wraps modulo 2^32.

## Operation
- Each FIFO has a 7-field record store, rd/wr pointers of width $clog2(DEPTH) that wrap naturally, and count_k of width $clog2(DEPTH)+1.
- `pop` = (count_1 ≠ 0) && (count_2 ≠ 0). When `pop` is true, both FIFOs pop together.
- Push k is accepted when `retire_k_i` && (count_k < DEPTH || pop).
  - Push into a full FIFO is legal when the same edge pops.
  - A record is never written over unread data.
- When `retire_k_i` && count_k == DEPTH && !pop:
  - The record is dropped.
  - `overflow_o` is set to 1 and stays 1 until reset.
  - Count and pointers are unchanged.
- Simultaneous push and pop on a FIFO: count_k is unchanged and both pointers advance.
- On an edge with `pop`:
  - Both head records are registered onto the `*_o` fields.
  - `retire_o` is set to 1.
  - `pairs_o` increments by 1.
- On an edge without `pop`: `retire_o` is set to 0 and the data outputs hold their last values.
- Pair order is strict FIFO order per copy: the n-th accepted record of copy 1 is always paired with the n-th accepted record of copy 2.
- `stall_k_o` = (count_k == DEPTH), derived combinationally from registered count. It is not qualified by a pending pop.
- No fields are decoded or compared here.
- Reset, including mid-operation, clears on the next posedge:
  - counts, pointers, `retire_o`, all data outputs, `overflow_o` and `pairs_o` all go to 0;
  - `stall_*_o` = 0;
  - FIFO contents are don't-care;
  - retire inputs sampled during that edge are ignored.

## Timing
- A record pushed at posedge t is first visible to `pop` evaluation after t.
- If the other FIFO already holds a record, the pair is emitted at posedge t+1: `retire_o` is high for the cycle t+1..t+2.
- Retire-to-`retire_o` latency is therefore 1 cycle for the later copy of a pair.
- Steady-state lockstep throughput is 1 pair per cycle, with one record per copy per cycle.
- The checker samples at negedge. Outputs change only at posedge and are stable around the negedge.
- `stall_k_o` asserts in the cycle after the push that fills FIFO k. It deasserts in the cycle after the pop that frees a slot.

## Test plan
1. **Lockstep, single pair.** After reset, both copies retire at posedge 0 with `instr`=0x00500093, `reg_rd`=5. Required: at posedge 1 `retire_o`=1 with both `instr_k_o`=0x00500093 and `pairs_o`=1. At posedge 2 `retire_o`=0 and the outputs hold.
2. **Skew.** Copy 1 retires instr A, B, C at posedges 0–2; copy 2 retires A, B, C at posedges 5–7. Required: `retire_o` pulses at posedges 6, 7, 8 with pairs (A,A), (B,B), (C,C) in that order. No overflow.
3. **Full, stall and drop (DEPTH=4).** Copy 1 retires R0..R4 on consecutive edges; copy 2 is idle. Required: `stall_1_o`=1 after the 4th push; R4 is dropped and `overflow_o`=1. Copy 2 then retires S0..S3. Required: pairs (R0,S0)..(R3,S3); `overflow_o` stays 1.
4. **Push into full with simultaneous pop.** FIFO 1 is full and FIFO 2 is empty. Copy 2 retires at posedge t, and copy 1 retires R4 at posedge t+1 while the pop occurs. Required: R4 is accepted, count_1 stays 4, `overflow_o`=0, and R4 is later paired as the 5th pair.
5. **Pointer wrap (DEPTH=4).** Ten lockstep retires with `instr`=0..9. Required: ten consecutive `retire_o` pulses with `instr` 0..9 in order, and `pairs_o`=10.
6. **Reset mid-operation.** With count_1=3, `overflow_o`=1 and `pairs_o`=7, assert `rst_i` for one edge while both copies retire. Required: next cycle all outputs are 0 and the retire inputs sampled at that edge are ignored. A subsequent lockstep retire yields `pairs_o`=1.
